calc_arbiter: RTL



---
 rtl/calc_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/calc_arbiter.sv
// calc_arbiter: two-port round-robin front end for the shared 4-bit Calculator.
// Grants one requester, drives the Calculator for a single cycle, captures the
// result (trapping divide-by-zero) and holds it on the winner's response port.
module calc_arbiter #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic [DATA_W-1:0] calc_a,
  output logic [DATA_W-1:0] calc_b,
  output logic [1:0]        calc_op,
  input  logic [RES_W-1:0]  calc_result,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [RES_W-1:0]  rsp0_data,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp1_data,
  output logic              rsp1_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;   // requester granted most recently
  logic                gnt_q, gnt_d;     // requester owning the op in flight
  logic                dz_q, dz_d;       // in-flight op is a divide by zero
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic [RES_W-1:0]    d0_q, d0_d, d1_q, d1_d;
  logic                e0_q, e0_d, e1_q, e1_d;
  logic                sel;
  logic [RES_W-1:0]    res;

  // Next-state, grant selection and response capture
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    dz_d       = dz_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // On a tie the requester not granted last wins; otherwise the lone valid one.
    sel        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    res        = dz_q ? {RES_W{1'b1}} : calc_result;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~sel;
          req1_ready = sel;
          gnt_d      = sel;
          a_d        = sel ? req1_a  : req0_a;
          b_d        = sel ? req1_b  : req0_b;
          op_d       = sel ? req1_op : req0_op;
          dz_d       = ((sel ? req1_op : req0_op) == 2'b11) &&
                       ((sel ? req1_b  : req0_b) == '0);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (gnt_q) begin
          d1_d = res;
          e1_d = dz_q;
        end else begin
          d0_d = res;
          e0_d = dz_q;
        end
        state_d = RESP;
      end
      RESP: begin
        if (gnt_q ? rsp1_ready : rsp0_ready) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      e0_q    <= 1'b0;
      e1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  // Operand registers only change on accept, so calc_* hold outside EXEC.
  assign calc_a     = a_q;
  assign calc_b     = b_q;
  assign calc_op    = op_q;
  assign rsp0_valid = (state_q == RESP) && !gnt_q;
  assign rsp1_valid = (state_q == RESP) &&  gnt_q;
  assign rsp0_data  = d0_q;
  assign rsp0_err   = e0_q;
  assign rsp1_data  = d1_q;
  assign rsp1_err   = e1_q;
  assign busy       = (state_q != IDLE);

endmodule
